sodor_scratchpad_2port: RTL and testbench

Two-port synchronous scratchpad memory that responds to the core's instruction-fetch (port 0) and data (port 1) request/response interfaces. Sits beside the 1-stage core in the tile and is the target of its `io_imem_*` and `io_dmem_*` buses. Each port accepts one request, returns a registered response the next cycle, and handles byte/half/word stores and sign- or zero-extended loads.

---
 rtl/sodor_mem_pkg.sv | 37 +++
 rtl/sodor_scratchpad_2port_if.sv | 46 ++++
 rtl/sodor_scratchpad_2port_spad_port_ctrl.sv | 69 ++++++
 rtl/sodor_scratchpad_2port.sv | 79 +++++++
 tb/tb_sodor_scratchpad_2port.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sodor_mem_pkg.sv
// Shared memory-request encodings and helpers for the Sodor scratchpad.
// Provides the command/type codes, the store byte-mask and the load extension.
package sodor_mem_pkg;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    // Unsigned variants share the mask of their signed counterparts; unknown codes act as MT_W.
    function automatic logic [3:0] typ_to_mask(input logic [2:0] typ);
        case (typ)
            MT_B, MT_BU: return 4'b0001;
            MT_H, MT_HU: return 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] typ);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (typ)
            MT_B:    return {{24{sh[7]}}, sh[7:0]};
            MT_BU:   return {24'h000000, sh[7:0]};
            MT_H:    return {{16{sh[15]}}, sh[15:0]};
            MT_HU:   return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/sodor_scratchpad_2port_if.sv
// Core-side request/response bundle for the two scratchpad ports (fetch and data).
// The core drives through the master modport; the scratchpad uses the slave modport.
interface sodor_scratchpad_2port_if;

    logic        io_core_ports_0_req_valid;
    logic [31:0] io_core_ports_0_req_bits_addr;
    logic        io_core_ports_0_resp_valid;
    logic [31:0] io_core_ports_0_resp_bits_data;

    logic        io_core_ports_1_req_valid;
    logic [31:0] io_core_ports_1_req_bits_addr;
    logic [31:0] io_core_ports_1_req_bits_data;
    logic        io_core_ports_1_req_bits_fcn;
    logic [2:0]  io_core_ports_1_req_bits_typ;
    logic        io_core_ports_1_resp_valid;
    logic [31:0] io_core_ports_1_resp_bits_data;

    modport master (
        output io_core_ports_0_req_valid,
        output io_core_ports_0_req_bits_addr,
        input  io_core_ports_0_resp_valid,
        input  io_core_ports_0_resp_bits_data,
        output io_core_ports_1_req_valid,
        output io_core_ports_1_req_bits_addr,
        output io_core_ports_1_req_bits_data,
        output io_core_ports_1_req_bits_fcn,
        output io_core_ports_1_req_bits_typ,
        input  io_core_ports_1_resp_valid,
        input  io_core_ports_1_resp_bits_data
    );

    modport slave (
        input  io_core_ports_0_req_valid,
        input  io_core_ports_0_req_bits_addr,
        output io_core_ports_0_resp_valid,
        output io_core_ports_0_resp_bits_data,
        input  io_core_ports_1_req_valid,
        input  io_core_ports_1_req_bits_addr,
        input  io_core_ports_1_req_bits_data,
        input  io_core_ports_1_req_bits_fcn,
        input  io_core_ports_1_req_bits_typ,
        output io_core_ports_1_resp_valid,
        output io_core_ports_1_resp_bits_data
    );

endinterface

// File: rtl/sodor_scratchpad_2port_spad_port_ctrl.sv
// Per-port IDLE/RESP controller: accepts one request, drives the array access in the
// accept cycle and presents a registered, extended response the following cycle.
module spad_port_ctrl
    import sodor_mem_pkg::*;
#(
    parameter int unsigned IdxW = 12
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_valid_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_data_i,
    input  logic            req_fcn_i,
    input  logic [2:0]      req_typ_i,
    input  logic [31:0]     rdata_i,
    output logic [IdxW-1:0] idx_o,
    output logic            we_o,
    output logic [3:0]      be_o,
    output logic [31:0]     wdata_o,
    output logic            resp_valid_o,
    output logic [31:0]     resp_data_o
);

    localparam logic StIdle = 1'b0;
    localparam logic StResp = 1'b1;

    logic        state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        accept;
    logic [1:0]  off;

    // Upper address bits only alias the index; the array wraps modulo its depth.
    logic unused_addr;
    assign unused_addr = ^req_addr_i[31:IdxW+2];

    assign off    = req_addr_i[1:0];
    assign idx_o  = req_addr_i[IdxW+1:2];
    // A request coinciding with reset is neither accepted nor committed.
    assign accept = !reset_i && (state_q == StIdle) && req_valid_i;

    assign we_o    = accept && (req_fcn_i == M_XWR);
    assign be_o    = typ_to_mask(req_typ_i) << off;
    assign wdata_o = req_data_i << {off, 3'b000};

    always_comb begin
        state_d = StIdle;
        data_d  = 32'h0;
        if (accept) begin
            state_d = StResp;
            if (req_fcn_i == M_XRD) begin
                data_d = load_extend(rdata_i, off, req_typ_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign resp_valid_o = (state_q == StResp);
    assign resp_data_o  = data_q;

endmodule

// File: rtl/sodor_scratchpad_2port.sv
// Two-port scratchpad: port 0 is a read-only instruction fetch port, port 1 a data port
// with byte/half/word stores; both share one array with byte-lane write enables.
module sodor_scratchpad_2port
    import sodor_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    sodor_scratchpad_2port_if.slave    io
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [IdxW-1:0] p0_idx, p1_idx;
    logic [31:0]     p0_rdata, p1_rdata;
    logic            p0_we, p1_we;
    logic [3:0]      p0_be, p1_be;
    logic [31:0]     p0_wdata, p1_wdata;

    // Port 0 has no write path and always fetches a whole aligned word.
    logic unused_p0;
    assign unused_p0 = ^{p0_we, p0_be, p0_wdata, io.io_core_ports_0_req_bits_addr[1:0]};

    spad_port_ctrl #(
        .IdxW (IdxW)
    ) u_port0 (
        .clk_i        (clock),
        .reset_i      (reset),
        .req_valid_i  (io.io_core_ports_0_req_valid),
        .req_addr_i   ({io.io_core_ports_0_req_bits_addr[31:2], 2'b00}),
        .req_data_i   (32'h0),
        .req_fcn_i    (M_XRD),
        .req_typ_i    (MT_W),
        .rdata_i      (p0_rdata),
        .idx_o        (p0_idx),
        .we_o         (p0_we),
        .be_o         (p0_be),
        .wdata_o      (p0_wdata),
        .resp_valid_o (io.io_core_ports_0_resp_valid),
        .resp_data_o  (io.io_core_ports_0_resp_bits_data)
    );

    spad_port_ctrl #(
        .IdxW (IdxW)
    ) u_port1 (
        .clk_i        (clock),
        .reset_i      (reset),
        .req_valid_i  (io.io_core_ports_1_req_valid),
        .req_addr_i   (io.io_core_ports_1_req_bits_addr),
        .req_data_i   (io.io_core_ports_1_req_bits_data),
        .req_fcn_i    (io.io_core_ports_1_req_bits_fcn),
        .req_typ_i    (io.io_core_ports_1_req_bits_typ),
        .rdata_i      (p1_rdata),
        .idx_o        (p1_idx),
        .we_o         (p1_we),
        .be_o         (p1_be),
        .wdata_o      (p1_wdata),
        .resp_valid_o (io.io_core_ports_1_resp_valid),
        .resp_data_o  (io.io_core_ports_1_resp_bits_data)
    );

    // Reads are combinational so a same-edge write is seen only by later accesses.
    assign p0_rdata = mem[p0_idx];
    assign p1_rdata = mem[p1_idx];

    always_ff @(posedge clock) begin
        if (p1_we) begin
            for (int b = 0; b < 4; b++) begin
                if (p1_be[b]) begin
                    mem[p1_idx][8*b +: 8] <= p1_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sodor_scratchpad_2port.sv
// Scoreboard bench for sodor_scratchpad_2port: a byte-level memory model predicts every
// response, and a monitor pops and compares whenever a port presents one.
module tb_sodor_scratchpad_2port;

    localparam int unsigned DEPTH = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sodor_scratchpad_2port_if bus ();

    sodor_scratchpad_2port #(
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int unsigned when;
        string       name;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic int nbytes(input logic [2:0] typ);
        if (typ == 3'd1 || typ == 3'd5) return 1;
        if (typ == 3'd2 || typ == 3'd6) return 2;
        return 4;
    endfunction

    // Loads gather n bytes starting at the byte offset; bytes beyond the word read as zero.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] typ);
        logic [31:0] w;
        logic [31:0] v;
        int          off;
        int          n;
        w   = model[widx(a)];
        off = int'(a[1:0]);
        n   = nbytes(typ);
        v   = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (off + k < 4) v[8*k +: 8] = w[8*(off+k) +: 8];
        end
        if ((typ == 3'd1 || typ == 3'd2) && v[8*n-1]) begin
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] typ, input logic [31:0] d);
        logic [31:0] w;
        int          off;
        w   = model[widx(a)];
        off = int'(a[1:0]);
        for (int k = 0; k < nbytes(typ); k++) begin
            if (off + k < 4) w[8*(off+k) +: 8] = d[8*k +: 8];
        end
        model[widx(a)] = w;
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        int   n;
        string pn;
        pn = (p == 0) ? "p0" : "p1";
        n  = (p == 0) ? q0.size() : q1.size();
        if (v) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_resp: got data %h, expected no response (cycle %0d)",
                         pn, d, cyc);
            end else begin
                if (p == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk({pn, "_", e.name}, d, e.data);
                chk({pn, "_", e.name, "_latency"}, cyc, e.when);
            end
        end else begin
            chk({pn, "_idle_data"}, d, 32'h0);
            while (n > 0) begin
                if (p == 0) e = q0[0];
                else        e = q1[0];
                if (e.when >= cyc) break;
                checks++;
                errors++;
                $display("FAIL %s_%s_missing: got no response, expected %h at cycle %0d",
                         pn, e.name, e.data, e.when);
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                n--;
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, bus.io_core_ports_0_resp_valid, bus.io_core_ports_0_resp_bits_data);
        mon(1, bus.io_core_ports_1_resp_valid, bus.io_core_ports_1_resp_bits_data);
    end

    // Called just after a negedge; occupies the accept and response cycles of both ports.
    task automatic xfer(input bit en0, input logic [31:0] a0, input bit en1, input logic fcn,
                        input logic [2:0] typ, input logic [31:0] a1, input logic [31:0] d1,
                        input string tag);
        exp_t e;
        // Port 0 prediction comes first: it must see the array before a same-cycle write.
        if (en0) begin
            e.data = model_load(a0 & 32'hFFFF_FFFC, 3'd3);
            e.when = cyc + 1;
            e.name = tag;
            q0.push_back(e);
            bus.io_core_ports_0_req_valid     = 1'b1;
            bus.io_core_ports_0_req_bits_addr = a0;
        end
        if (en1) begin
            e.when = cyc + 1;
            e.name = tag;
            if (fcn) begin
                e.data = 32'h0;
                model_store(a1, typ, d1);
            end else begin
                e.data = model_load(a1, typ);
            end
            q1.push_back(e);
            bus.io_core_ports_1_req_valid     = 1'b1;
            bus.io_core_ports_1_req_bits_addr = a1;
            bus.io_core_ports_1_req_bits_data = d1;
            bus.io_core_ports_1_req_bits_fcn  = fcn;
            bus.io_core_ports_1_req_bits_typ  = typ;
        end
        @(negedge clock);
        bus.io_core_ports_0_req_valid = 1'b0;
        bus.io_core_ports_1_req_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hold_addr;
        logic [2:0]  rd_typs [8];
        logic [2:0]  wr_typs [6];
        exp_t        e;

        rd_typs = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0, 3'd4, 3'd7};
        wr_typs = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd7};

        bus.io_core_ports_0_req_valid     = 1'b0;
        bus.io_core_ports_0_req_bits_addr = 32'h0;
        bus.io_core_ports_1_req_valid     = 1'b0;
        bus.io_core_ports_1_req_bits_addr = 32'h0;
        bus.io_core_ports_1_req_bits_data = 32'h0;
        bus.io_core_ports_1_req_bits_fcn  = 1'b0;
        bus.io_core_ports_1_req_bits_typ  = 3'd3;

        repeat (3) @(negedge clock);
        chk("reset_p0_valid", {31'h0, bus.io_core_ports_0_resp_valid}, 32'h0);
        chk("reset_p1_valid", {31'h0, bus.io_core_ports_1_resp_valid}, 32'h0);
        chk("reset_p0_data", bus.io_core_ports_0_resp_bits_data, 32'h0);
        chk("reset_p1_data", bus.io_core_ports_1_resp_bits_data, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Give the low 256 words defined contents so every later read is predictable.
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'(i * 4), $urandom, "init");
        end

        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'h100, 32'hDEADBEEF, "wr_w_100");
        xfer(1'b1, 32'h100, 1'b0, 1'b0, 3'd3, 32'h0, 32'h0, "fetch_100");
        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 32'h103, 32'h00000080, "wr_b_103");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd1, 32'h103, 32'h0, "rd_b_103");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd5, 32'h103, 32'h0, "rd_bu_103");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd3, 32'h100, 32'h0, "rd_w_100");
        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'h200, 32'h0, "wr_w_200");
        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd2, 32'h202, 32'h1234, "wr_h_202");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd3, 32'h200, 32'h0, "rd_w_200");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd6, 32'h200, 32'h0, "rd_hu_200");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd2, 32'h202, 32'h0, "rd_h_202");
        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'h40, 32'hAAAAAAAA, "wr_w_40");
        xfer(1'b1, 32'h40, 1'b1, 1'b1, 3'd3, 32'h40, 32'h11111111, "rbw_40");
        xfer(1'b1, 32'h40, 1'b0, 1'b0, 3'd3, 32'h0, 32'h0, "fetch_40_new");
        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'h4010, 32'hCAFEF00D, "wr_wrap_4010");
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd3, 32'h0010, 32'h0, "rd_wrap_10");
        xfer(1'b1, 32'h0012, 1'b0, 1'b0, 3'd3, 32'h0, 32'h0, "fetch_wrap_10");

        // Held fetch request: responds every other cycle.
        hold_addr = 32'h100;
        for (int k = 0; k < 3; k++) begin
            e.data = model_load(hold_addr, 3'd3);
            e.when = cyc + 1 + 2 * k;
            e.name = "hold";
            q0.push_back(e);
        end
        bus.io_core_ports_0_req_valid     = 1'b1;
        bus.io_core_ports_0_req_bits_addr = hold_addr;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hold_valid_%0d", i), {31'h0, bus.io_core_ports_0_resp_valid},
                32'(i % 2));
            @(negedge clock);
        end
        bus.io_core_ports_0_req_valid = 1'b0;
        @(negedge clock);

        // A write whose accept edge coincides with reset must not land.
        xfer(1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 32'h300, 32'h600DF00D, "wr_w_300");
        bus.io_core_ports_1_req_valid     = 1'b1;
        bus.io_core_ports_1_req_bits_addr = 32'h300;
        bus.io_core_ports_1_req_bits_data = 32'h55555555;
        bus.io_core_ports_1_req_bits_fcn  = 1'b1;
        bus.io_core_ports_1_req_bits_typ  = 3'd3;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_accept_p1_valid", {31'h0, bus.io_core_ports_1_resp_valid}, 32'h0);
        bus.io_core_ports_1_req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        xfer(1'b0, 32'h0, 1'b1, 1'b0, 3'd3, 32'h300, 32'h0, "rd_w_300_after_rst");

        // Reset raised during a response cycle: the accepted write stays committed.
        e.data = 32'h0;
        e.when = cyc + 1;
        e.name = "wr_w_304";
        q1.push_back(e);
        model_store(32'h304, 3'd3, 32'h0BADCAFE);
        bus.io_core_ports_1_req_valid     = 1'b1;
        bus.io_core_ports_1_req_bits_addr = 32'h304;
        bus.io_core_ports_1_req_bits_data = 32'h0BADCAFE;
        bus.io_core_ports_1_req_bits_fcn  = 1'b1;
        bus.io_core_ports_1_req_bits_typ  = 3'd3;
        @(negedge clock);
        bus.io_core_ports_1_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_resp_p1_valid", {31'h0, bus.io_core_ports_1_resp_valid}, 32'h0);
        reset = 1'b0;
        xfer(1'b1, 32'h304, 1'b1, 1'b0, 3'd3, 32'h304, 32'h0, "rd_304_after_rst");

        for (int i = 0; i < 300; i++) begin
            bit          en0, en1, fcn;
            logic [31:0] a0, a1;
            logic [2:0]  typ;
            en0 = 1'($urandom_range(0, 1));
            en1 = 1'($urandom_range(0, 1));
            fcn = 1'($urandom_range(0, 1));
            a0  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255) * 4)
                | 32'($urandom_range(0, 3));
            a1  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255) * 4)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a1 = a0;
            typ = fcn ? wr_typs[$urandom_range(0, 5)] : rd_typs[$urandom_range(0, 7)];
            xfer(en0, a0, en1, fcn, typ, a1, $urandom, "rand");
        end

        repeat (3) @(negedge clock);
        chk("drain_q0", 32'(q0.size()), 32'h0);
        chk("drain_q1", 32'(q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
